// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button synchronizer, tick-sampled debouncer, press/release/long-press pulses
// Long-press counting is built only when BUTTON_LONG_PRESS_EN is defined; otherwise btn_long is tied low.
module button_conditioner #(
   parameter int NBTN       = 4,
   parameter int TICK_DIV   = 500000,
   parameter int STABLE_CNT = 3,
   parameter int LONG_TICKS = 100
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NBTN-1:0] button,
   output logic            tick,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] btn_press,
   output logic [NBTN-1:0] btn_release,
   output logic [NBTN-1:0] btn_long
);
   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = $clog2(STABLE_CNT + 1);
   localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT);

   logic [NBTN-1:0] sync_meta;
   logic [NBTN-1:0] sync;
   logic [TW-1:0]   presc;
   logic            tick_int;
   logic [NBTN-1:0] level_q;
   logic [NBTN-1:0] press_q;
   logic [NBTN-1:0] release_q;
   logic [NBTN-1:0] toggle;
   logic [SW-1:0]   stab_cnt  [NBTN];
   logic [SW-1:0]   stab_next [NBTN];

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= button;
         sync      <= sync_meta;
      end
   end

   assign tick_int = (presc == TICK_LAST);

   always_ff @(posedge clock) begin
      if (reset || tick_int) begin
         presc <= '0;
      end else begin
         presc <= presc + TW'(1);
      end
   end

   // Counters only move on a tick, so anything between samples is never seen.
   always_comb begin
      for (int i = 0; i < NBTN; i++) begin
         stab_next[i] = stab_cnt[i];
         toggle[i]    = 1'b0;
         if (tick_int) begin
            if (sync[i] != level_q[i]) begin
               if (stab_cnt[i] + SW'(1) == STABLE_LAST) begin
                  stab_next[i] = '0;
                  toggle[i]    = 1'b1;
               end else begin
                  stab_next[i] = stab_cnt[i] + SW'(1);
               end
            end else begin
               stab_next[i] = '0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < NBTN; i++) begin
            stab_cnt[i] <= '0;
         end
      end else begin
         level_q   <= level_q ^ toggle;
         press_q   <= toggle & ~level_q;
         release_q <= toggle & level_q;
         for (int i = 0; i < NBTN; i++) begin
            stab_cnt[i] <= stab_next[i];
         end
      end
   end

   assign tick        = tick_int & ~reset;
   assign btn_level   = level_q & {NBTN{~reset}};
   assign btn_press   = press_q & {NBTN{~reset}};
   assign btn_release = release_q & {NBTN{~reset}};

`ifdef BUTTON_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_TICKS + 1);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS);

   logic [LW-1:0]   long_cnt [NBTN];
   logic [NBTN-1:0] long_q;

   // The press tick itself is not counted; the count saturates so the pulse fires once per hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         long_q <= '0;
         for (int i = 0; i < NBTN; i++) begin
            long_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            long_q[i] <= 1'b0;
            if (!level_q[i] || toggle[i]) begin
               long_cnt[i] <= '0;
            end else if (tick_int && long_cnt[i] != LONG_LAST) begin
               long_cnt[i] <= long_cnt[i] + LW'(1);
               long_q[i]   <= (long_cnt[i] + LW'(1) == LONG_LAST);
            end
         end
      end
   end

   assign btn_long = long_q & {NBTN{~reset}};
`else
   logic unused_long_ticks;
   assign unused_long_ticks = ^LONG_TICKS;
   assign btn_long          = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and randomized bench for button_conditioner with a tick-level reference model
// Long-press expectations follow BUTTON_LONG_PRESS_EN.
module tb_button_conditioner;
   localparam int NBTN       = 4;
   localparam int TICK_DIV   = 4;
   localparam int STABLE_CNT = 3;
   localparam int LONG_TICKS = 5;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [NBTN-1:0] button = '1;
   logic            tick;
   logic [NBTN-1:0] btn_level;
   logic [NBTN-1:0] btn_press;
   logic [NBTN-1:0] btn_release;
   logic [NBTN-1:0] btn_long;

   always #5 clock = ~clock;

   button_conditioner #(
      .NBTN(NBTN), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT), .LONG_TICKS(LONG_TICKS)
   ) dut (
      .clock(clock), .reset(reset), .button(button), .tick(tick),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: pin delay line, cycles since reset, per-channel run lengths and hold times.
   logic [NBTN-1:0] m_meta = '0, m_sync = '0, m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
   int n = 0;
   int run  [NBTN];
   int held [NBTN];
   int obs_press [NBTN];
   int obs_rel   [NBTN];
   int obs_long  [NBTN];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      logic [NBTN-1:0] s;
      logic            was;
      bit              t;
      if (reset) begin
         m_meta = '0; m_sync = '0; m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
         n = 0;
         for (int i = 0; i < NBTN; i++) begin run[i] = 0; held[i] = 0; end
         return;
      end
      s = m_sync;
      t = (n % TICK_DIV) == TICK_DIV - 1;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < NBTN; i++) begin
         was = m_level[i];
         if (t) begin
            if (s[i] != m_level[i]) begin
               run[i]++;
               if (run[i] == STABLE_CNT) begin
                  run[i]     = 0;
                  m_level[i] = s[i];
                  if (s[i]) m_press[i] = 1'b1;
                  else      m_rel[i]   = 1'b1;
               end
            end else begin
               run[i] = 0;
            end
`ifdef BUTTON_LONG_PRESS_EN
            if (was && m_level[i] && held[i] < LONG_TICKS) begin
               held[i]++;
               if (held[i] == LONG_TICKS) m_long[i] = 1'b1;
            end
`endif
         end
         if (!m_level[i]) held[i] = 0;
      end
      m_sync = m_meta;
      m_meta = button;
      n++;
   endtask

   task automatic cyc();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check("tick", tick, !reset && (n % TICK_DIV) == TICK_DIV - 1);
      check("btn_level", btn_level, m_level);
      check("btn_press", btn_press, m_press);
      check("btn_release", btn_release, m_rel);
      check("btn_long", btn_long, m_long);
      check("press_and_release", btn_press & btn_release, 0);
      for (int i = 0; i < NBTN; i++) begin
         obs_press[i] += int'(btn_press[i]);
         obs_rel[i]   += int'(btn_release[i]);
         obs_long[i]  += int'(btn_long[i]);
      end
   endtask

   task automatic zero_obs();
      for (int i = 0; i < NBTN; i++) begin
         obs_press[i] = 0; obs_rel[i] = 0; obs_long[i] = 0;
      end
   endtask

   initial begin
      int first_tick;
      int lat;
      int ticks;
      int hold;
      logic [NBTN-1:0] flip;

      for (int i = 0; i < NBTN; i++) begin run[i] = 0; held[i] = 0; end
      zero_obs();

      // Reset with all pins held, then the held buttons debounce into presses.
      repeat (3) cyc();
      check("reset_outputs", {tick, btn_level, btn_press, btn_release, btn_long}, 0);
      @(negedge clock);
      reset = 1'b0;
      // The negedge above already sits in the first clock after release (count 0).
      first_tick = -1;
      for (int c = 1; c <= 20 && first_tick < 0; c++) begin
         cyc();
         if (tick) first_tick = c;
      end
      check("first_tick_clock", first_tick + 1, TICK_DIV);
      for (int k = 0; k < 60 && btn_level != '1; k++) cyc();
      check("held_after_reset_level", btn_level, 4'hF);
      for (int i = 0; i < NBTN; i++) check("held_after_reset_press", obs_press[i], 1);
      button = '0;
      repeat (60) cyc();

      // Clean press on channel 0.
      zero_obs();
      button[0] = 1'b1;
      lat = 0;
      while (!btn_level[0] && lat < 100) begin cyc(); lat++; end
      check("press_latency_in_range",
            (lat >= (STABLE_CNT - 1) * TICK_DIV + 3) && (lat <= STABLE_CNT * TICK_DIV + 2), 1);
      repeat (10) cyc();
      check("press0_count", obs_press[0], 1);
      check("others_idle_level", btn_level[3:1], 0);
      check("others_idle_press", obs_press[1] + obs_press[2] + obs_press[3], 0);

      // Bounce on channel 1: 2 ticks high, 1 tick low, four times, aligned to the tick.
      zero_obs();
      for (int k = 0; k < 10 && !tick; k++) cyc();
      for (int r = 0; r < 4; r++) begin
         button[1] = 1'b1;
         repeat (2 * TICK_DIV) cyc();
         button[1] = 1'b0;
         repeat (TICK_DIV) cyc();
      end
      repeat (20) cyc();
      check("bounce_level", btn_level[1], 0);
      check("bounce_press", obs_press[1], 0);
      check("bounce_release", obs_rel[1], 0);

      // Release on channel 2.
      button[2] = 1'b1;
      for (int k = 0; k < 100 && !btn_level[2]; k++) cyc();
      check("ch2_level_set", btn_level[2], 1);
      repeat (3) cyc();
      zero_obs();
      button[2] = 1'b0;
      for (int k = 0; k < 100 && btn_level[2]; k++) cyc();
      repeat (5) cyc();
      check("release2_count", obs_rel[2], 1);
      check("release2_no_press", obs_press[2], 0);

      // Long press on channel 3.
      zero_obs();
      button[3] = 1'b1;
      for (int k = 0; k < 100 && obs_press[3] == 0; k++) cyc();
      check("ch3_pressed", obs_press[3], 1);
`ifdef BUTTON_LONG_PRESS_EN
      ticks = 0;
      for (int k = 0; k < 20 * TICK_DIV && obs_long[3] == 0; k++) begin
         cyc();
         if (tick) ticks++;
      end
      check("long_ticks_after_press", ticks, LONG_TICKS);
      repeat (30 * TICK_DIV) cyc();
      check("long_single_pulse", obs_long[3], 1);
`else
      repeat (30 * TICK_DIV) cyc();
      check("long_disabled", obs_long[3], 0);
`endif

      // Reset after two stable ticks of channel 0 discards the partial count.
      button[0] = 1'b0;
      for (int k = 0; k < 100 && btn_level[0]; k++) cyc();
      check("ch0_released", btn_level[0], 0);
      button[0] = 1'b1;
      repeat (2) cyc();
      ticks = 0;
      for (int k = 0; k < 40 && ticks < 2; k++) begin
         cyc();
         if (tick) ticks++;
      end
      cyc();
      check("mid_count_level_low", btn_level[0], 0);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      ticks = 0;
      for (int k = 0; k < 100 && !btn_level[0]; k++) begin
         cyc();
         if (tick && !btn_level[0]) ticks++;
      end
      check("ticks_after_reset_to_level", ticks, STABLE_CNT);
      check("level_after_reset", btn_level[0], 1);

      // Randomized pin activity with occasional resets; the model checks every clock.
      for (int it = 0; it < 500; it++) begin
         flip   = NBTN'($urandom) & NBTN'($urandom);
         button = button ^ flip;
         reset  = ($urandom_range(0, 40) == 0);
         hold   = $urandom_range(1, 24);
         repeat (hold) begin
            cyc();
            reset = 1'b0;
         end
      end
      reset = 1'b0;
      repeat (20) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
